// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO / divide sequencer: op codes, FSM state
// encoding and default datapath / watchdog sizing.
package muldiv_pkg;

    localparam int DEF_W       = 32;
    localparam int DEF_TIMEOUT = 40;
    localparam int DEF_TW      = 6;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_DIV  = 3'd1;
    localparam logic [2:0] OP_MTHI = 3'd2;
    localparam logic [2:0] OP_MTLO = 3'd3;
    localparam logic [2:0] OP_MFHI = 3'd4;
    localparam logic [2:0] OP_MFLO = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ABORT = 2'd3
    } state_t;

    // True for the op codes this block acts on; 0, 6 and 7 are ignored.
    function automatic logic is_hilo_op(input logic [2:0] op);
        return (op >= OP_DIV) && (op <= OP_MFLO);
    endfunction

endpackage

// File: rtl/hilo_div_ctrl.sv
// HI/LO register owner and divide sequencer. Launches the external signed
// divider, commits its results, stalls decode while a divide is in flight
// and aborts the divider on flush or watchdog expiry.
module hilo_div_ctrl
    import muldiv_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int TW      = DEF_TW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         op_valid,
    input  logic [2:0]   op_code,
    input  logic [W-1:0] rs_val,
    input  logic [W-1:0] rt_val,
    input  logic         flush,
    output logic         stall,
    output logic [W-1:0] rd_data,
    output logic [W-1:0] hi_out,
    output logic [W-1:0] lo_out,
    output logic         dz_flag,
    output logic         to_err,
    output logic         div_start,
    output logic         div_rst,
    output logic [W-1:0] div_dividend,
    output logic [W-1:0] div_divisor,
    input  logic         div_end,
    input  logic         div_by_zero,
    input  logic [W-1:0] div_hi,
    input  logic [W-1:0] div_lo
);

    localparam logic [TW-1:0] WDOG_LAST = TW'(TIMEOUT - 1);

    state_t        state;
    state_t        state_next;
    logic [W-1:0]  hi_q;
    logic [W-1:0]  lo_q;
    logic [TW-1:0] wdog;
    logic          accept;
    logic          div_done;
    logic          wdog_expired;

    assign accept       = (state == ST_IDLE) && op_valid && !flush;
    assign div_done     = div_end || div_by_zero;
    assign wdog_expired = (state == ST_WAIT) && !flush && !div_done && (wdog == WDOG_LAST);

    assign hi_out    = hi_q;
    assign lo_out    = lo_q;
    assign div_start = (state == ST_START);
    assign div_rst   = (state == ST_ABORT);
    assign to_err    = wdog_expired;
    assign stall     = op_valid && is_hilo_op(op_code) && (state != ST_IDLE) && !flush;

    // Move-from reads return the register value before this cycle's edge.
    always_comb begin
        rd_data = '0;
        if (accept && (op_code == OP_MFHI)) begin
            rd_data = hi_q;
        end else if (accept && (op_code == OP_MFLO)) begin
            rd_data = lo_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: flush beats completion, completion beats the watchdog.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept && (op_code == OP_DIV)) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                state_next = flush ? ST_ABORT : ST_WAIT;
            end
            ST_WAIT: begin
                if (flush) begin
                    state_next = ST_ABORT;
                end else if (div_done) begin
                    state_next = ST_IDLE;
                end else if (wdog == WDOG_LAST) begin
                    state_next = ST_ABORT;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Architectural HI/LO, sticky divide-by-zero flag, operand latches and watchdog.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q         <= '0;
            lo_q         <= '0;
            dz_flag      <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            wdog         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (op_code)
                            OP_DIV: begin
                                div_dividend <= rs_val;
                                div_divisor  <= rt_val;
                                dz_flag      <= 1'b0;
                            end
                            OP_MTHI: hi_q <= rs_val;
                            OP_MTLO: lo_q <= rs_val;
                            default: ;
                        endcase
                    end
                end
                ST_START: begin
                    wdog <= '0;
                end
                ST_WAIT: begin
                    wdog <= wdog + TW'(1);
                    if (!flush) begin
                        if (div_by_zero) begin
                            dz_flag <= 1'b1;
                        end else if (div_end) begin
                            hi_q <= div_hi;
                            lo_q <= div_lo;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Bench for hilo_div_ctrl with a behavioural stub divider (fixed latency,
// optional hang) and a scoreboard of expected HI/LO/read results.
module tb_hilo_div_ctrl;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         op_valid;
    logic [2:0]   op_code;
    logic [W-1:0] rs_val;
    logic [W-1:0] rt_val;
    logic         flush;
    logic         stall;
    logic [W-1:0] rd_data;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;
    logic         dz_flag;
    logic         to_err;
    logic         div_start;
    logic         div_rst;
    logic [W-1:0] div_dividend;
    logic [W-1:0] div_divisor;
    logic         div_end;
    logic         div_by_zero;
    logic [W-1:0] div_hi;
    logic [W-1:0] div_lo;

    hilo_div_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .op_valid     (op_valid),
        .op_code      (op_code),
        .rs_val       (rs_val),
        .rt_val       (rt_val),
        .flush        (flush),
        .stall        (stall),
        .rd_data      (rd_data),
        .hi_out       (hi_out),
        .lo_out       (lo_out),
        .dz_flag      (dz_flag),
        .to_err       (to_err),
        .div_start    (div_start),
        .div_rst      (div_rst),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_end      (div_end),
        .div_by_zero  (div_by_zero),
        .div_hi       (div_hi),
        .div_lo       (div_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub signed divider: result div_latency cycles after the start pulse.
    int           div_latency = 33;
    bit           div_hang = 1'b0;
    int           div_cnt;
    logic         div_busy;
    logic [W-1:0] pend_hi;
    logic [W-1:0] pend_lo;
    logic         pend_dz;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_busy    <= 1'b0;
            div_cnt     <= 0;
            div_end     <= 1'b0;
            div_by_zero <= 1'b0;
            div_hi      <= '0;
            div_lo      <= '0;
        end else if (div_rst) begin
            div_busy    <= 1'b0;
            div_end     <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            div_end     <= 1'b0;
            div_by_zero <= 1'b0;
            if (div_start) begin
                div_busy <= 1'b1;
                div_cnt  <= div_latency - 1;
                if (div_divisor == '0) begin
                    pend_dz <= 1'b1;
                end else begin
                    pend_dz <= 1'b0;
                    pend_hi <= $signed(div_dividend) % $signed(div_divisor);
                    pend_lo <= $signed(div_dividend) / $signed(div_divisor);
                end
            end else if (div_busy && !div_hang) begin
                if (div_cnt <= 1) begin
                    div_busy <= 1'b0;
                    if (pend_dz) begin
                        div_by_zero <= 1'b1;
                    end else begin
                        div_end <= 1'b1;
                        div_hi  <= pend_hi;
                        div_lo  <= pend_lo;
                    end
                end else begin
                    div_cnt <= div_cnt - 1;
                end
            end
        end
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic [31:0] exp_rd;
        logic        exp_dz;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } div_exp_t;

    vec_t        vecs[12];
    div_exp_t    div_q[$];
    logic [31:0] rd_q[$];
    div_exp_t    de;
    logic [31:0] exp_rd;
    logic [31:0] rd_seen;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    int          n_checks = 0;
    int          n_fail = 0;
    int          k;
    int          stall_cycles;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Present one op, hold it while stalled, return one cycle after acceptance.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] rs,
                                 input logic [31:0] rt, output logic [31:0] rd);
        int guard;
        op_valid = 1'b1;
        op_code  = op;
        rs_val   = rs;
        rt_val   = rt;
        #1;
        guard = 0;
        while (stall && guard < 200) begin
            nextCycle();
            guard++;
        end
        checkOutput("accept_bound", 32'(guard >= 200), 32'd0);
        rd = rd_data;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        op_code  = OP_NOP;
        #1;
    endtask

    // Wait (bounded) for the divider completion pulse, then past the commit edge.
    task automatic waitDivDone();
        int guard;
        guard = 0;
        while (!(div_end || div_by_zero) && guard < 100) begin
            nextCycle();
            guard++;
        end
        checkOutput("div_done_bound", 32'(guard >= 100), 32'd0);
        nextCycle();
    endtask

    initial begin
        rst      = 1'b0;
        op_valid = 1'b0;
        op_code  = OP_NOP;
        rs_val   = '0;
        rt_val   = '0;
        flush    = 1'b0;

        vecs[0]  = '{OP_DIV,  32'd100,        32'd7,          32'd2,          32'd14,         32'd0,          1'b0};
        vecs[1]  = '{OP_MFLO, 32'd0,          32'd0,          32'd2,          32'd14,         32'd14,         1'b0};
        vecs[2]  = '{OP_MFHI, 32'd0,          32'd0,          32'd2,          32'd14,         32'd2,          1'b0};
        vecs[3]  = '{OP_DIV,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFF2,  32'd0,          1'b0};
        vecs[4]  = '{OP_MTHI, 32'd5,          32'd0,          32'd5,          32'hFFFF_FFF2,  32'd0,          1'b0};
        vecs[5]  = '{OP_DIV,  32'd9,          32'd0,          32'd5,          32'hFFFF_FFF2,  32'd0,          1'b1};
        vecs[6]  = '{OP_MFHI, 32'd0,          32'd0,          32'd5,          32'hFFFF_FFF2,  32'd5,          1'b1};
        vecs[7]  = '{OP_DIV,  32'd8,          32'd2,          32'd0,          32'd4,          32'd0,          1'b0};
        vecs[8]  = '{OP_MTLO, 32'hDEAD_BEEF,  32'd0,          32'd0,          32'hDEAD_BEEF,  32'd0,          1'b0};
        vecs[9]  = '{OP_MFLO, 32'd0,          32'd0,          32'd0,          32'hDEAD_BEEF,  32'hDEAD_BEEF,  1'b0};
        vecs[10] = '{3'd6,    32'd1,          32'd1,          32'd0,          32'hDEAD_BEEF,  32'd0,          1'b0};
        vecs[11] = '{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'd1,          32'hFFFF_FFFD,  32'd0,          1'b0};

        // Reset state while rst is held low.
        #12;
        checkOutput("reset_hi", hi_out, 32'd0);
        checkOutput("reset_lo", lo_out, 32'd0);
        checkOutput("reset_dz", 32'(dz_flag), 32'd0);
        checkOutput("reset_start", 32'(div_start), 32'd0);
        checkOutput("reset_divrst", 32'(div_rst), 32'd0);
        checkOutput("reset_dividend", div_dividend, 32'd0);
        #11;
        rst = 1'b1;
        @(negedge clk);
        #1;

        // Table-driven sequence through the scoreboard.
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].op == OP_DIV) begin
                div_q.push_back('{vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_dz});
                applyStimulus(vecs[i].op, vecs[i].rs, vecs[i].rt, rd_seen);
                checkOutput($sformatf("v%0d_div_start", i), 32'(div_start), 32'd1);
                checkOutput($sformatf("v%0d_dividend", i), div_dividend, vecs[i].rs);
                checkOutput($sformatf("v%0d_divisor", i), div_divisor, vecs[i].rt);
                checkOutput($sformatf("v%0d_dz_cleared", i), 32'(dz_flag), 32'd0);
                nextCycle();
                checkOutput($sformatf("v%0d_start_once", i), 32'(div_start), 32'd0);
                waitDivDone();
                de = div_q.pop_front();
                checkOutput($sformatf("v%0d_hi", i), hi_out, de.hi);
                checkOutput($sformatf("v%0d_lo", i), lo_out, de.lo);
                checkOutput($sformatf("v%0d_dz", i), 32'(dz_flag), 32'(de.dz));
            end else begin
                rd_q.push_back(vecs[i].exp_rd);
                applyStimulus(vecs[i].op, vecs[i].rs, vecs[i].rt, rd_seen);
                exp_rd = rd_q.pop_front();
                checkOutput($sformatf("v%0d_rd", i), rd_seen, exp_rd);
                checkOutput($sformatf("v%0d_hi", i), hi_out, vecs[i].exp_hi);
                checkOutput($sformatf("v%0d_lo", i), lo_out, vecs[i].exp_lo);
                checkOutput($sformatf("v%0d_dz", i), 32'(dz_flag), 32'(vecs[i].exp_dz));
            end
        end

        // MFLO issued right behind a DIV stalls until the commit, then reads the new LO.
        div_q.push_back('{32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0});
        applyStimulus(OP_DIV, 32'hFFFF_FF9C, 32'd7, rd_seen);
        op_valid = 1'b1;
        op_code  = OP_MFLO;
        #1;
        stall_cycles = 0;
        while (stall && stall_cycles < 200) begin
            stall_cycles++;
            nextCycle();
        end
        checkOutput("mflo_stall_cycles", 32'(stall_cycles), 32'd34);
        checkOutput("mflo_after_div", rd_data, 32'hFFFF_FFF2);
        de = div_q.pop_front();
        checkOutput("div_neg_hi", hi_out, de.hi);
        checkOutput("div_neg_lo", lo_out, de.lo);
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        op_code  = OP_NOP;
        #1;
        m_hi = 32'hFFFF_FFFE;
        m_lo = 32'hFFFF_FFF2;

        // Flush in IDLE drops the op without stalling.
        op_valid = 1'b1;
        op_code  = OP_MTHI;
        rs_val   = 32'h1234_5678;
        flush    = 1'b1;
        #1;
        checkOutput("idle_flush_stall", 32'(stall), 32'd0);
        nextCycle();
        op_valid = 1'b0;
        flush    = 1'b0;
        #1;
        checkOutput("idle_flush_hi", hi_out, m_hi);

        // Flush ten cycles into WAIT aborts the divide.
        applyStimulus(OP_DIV, 32'd50, 32'd5, rd_seen);
        for (int i = 0; i < 10; i++) nextCycle();
        flush = 1'b1;
        #1;
        checkOutput("flush_wait_toerr", 32'(to_err), 32'd0);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        #1;
        checkOutput("flush_divrst", 32'(div_rst), 32'd1);
        nextCycle();
        checkOutput("flush_divrst_once", 32'(div_rst), 32'd0);
        for (int i = 0; i < 40; i++) nextCycle();
        checkOutput("flush_hi_kept", hi_out, m_hi);
        checkOutput("flush_lo_kept", lo_out, m_lo);

        // Flush in the same cycle as div_end discards the result.
        applyStimulus(OP_DIV, 32'd77, 32'd7, rd_seen);
        k = 0;
        while (!div_end && k < 100) begin
            nextCycle();
            k++;
        end
        checkOutput("coinc_end_bound", 32'(k >= 100), 32'd0);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        #1;
        checkOutput("coinc_divrst", 32'(div_rst), 32'd1);
        checkOutput("coinc_hi_kept", hi_out, m_hi);
        checkOutput("coinc_lo_kept", lo_out, m_lo);
        nextCycle();

        // A hung divider trips the watchdog in the 40th WAIT cycle.
        div_hang = 1'b1;
        applyStimulus(OP_DIV, 32'd1, 32'd1, rd_seen);
        k = 1;
        while (!to_err && k < 100) begin
            nextCycle();
            k++;
        end
        checkOutput("toerr_cycle", 32'(k), 32'd41);
        checkOutput("toerr_no_divrst", 32'(div_rst), 32'd0);
        nextCycle();
        checkOutput("toerr_pulse_once", 32'(to_err), 32'd0);
        checkOutput("toerr_divrst", 32'(div_rst), 32'd1);
        op_valid = 1'b1;
        op_code  = OP_MFHI;
        #1;
        checkOutput("abort_stall", 32'(stall), 32'd1);
        nextCycle();
        checkOutput("abort_stall_drop", 32'(stall), 32'd0);
        checkOutput("abort_mfhi", rd_data, m_hi);
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        op_code  = OP_NOP;
        div_hang = 1'b0;
        #1;

        // Asynchronous reset in the middle of WAIT.
        applyStimulus(OP_DIV, 32'd100, 32'd7, rd_seen);
        for (int i = 0; i < 5; i++) nextCycle();
        #2;
        rst = 1'b0;
        #1;
        checkOutput("areset_hi", hi_out, 32'd0);
        checkOutput("areset_lo", lo_out, 32'd0);
        checkOutput("areset_dividend", div_dividend, 32'd0);
        checkOutput("areset_divisor", div_divisor, 32'd0);
        checkOutput("areset_ctrl", {29'd0, div_start, div_rst, to_err}, 32'd0);
        op_valid = 1'b1;
        op_code  = OP_MFHI;
        #1;
        checkOutput("areset_stall", 32'(stall), 32'd0);
        op_valid = 1'b0;
        op_code  = OP_NOP;
        @(negedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        #1;
        div_q.push_back('{32'd0, 32'd2, 1'b0});
        applyStimulus(OP_DIV, 32'd6, 32'd3, rd_seen);
        waitDivDone();
        de = div_q.pop_front();
        checkOutput("post_reset_hi", hi_out, de.hi);
        checkOutput("post_reset_lo", lo_out, de.lo);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
